vending_change_fsm: RTL and testbench
=====================================

// Module: vending_change_fsm
// PURPOSE
//  Parametrised successor to the single-price newspaper vendor FSM. Accepts up to three coin
//  denominations and accumulates credit toward a configurable PRICE. Vends on request, then
//  returns change as a train of smallest-coin pulses. Supports cancel/refund, rejects coins
//  while vending or paying out, and exposes the running credit.
//  Sits between the coin-acceptor front end and the dispenser/coin-hopper drivers.
// PARAMETERS
//  PRICE     15  item price in cents; must be a multiple of COIN_A
//  COIN_A     5  value of coin code 2'b01; also the change-pulse unit
//  COIN_B    10  value of coin code 2'b10; must be a multiple of COIN_A
//  COIN_C    25  value of coin code 2'b11; must be a multiple of COIN_A
//  CREDIT_W   6  credit register width; must hold PRICE-COIN_A+max(COIN_B,COIN_C)
// PORTS
//  clk          in   1         single clock, rising edge
//  rst          in   1         asynchronous, active-low reset
//  coinin       in   2         00 none, 01 COIN_A, 10 COIN_B, 11 COIN_C; one coin per cycle
//  outpaper     in   1         vend request, sampled each cycle
//  cancel       in   1         refund request, sampled each cycle
//  newspaper    out  1         1-cycle vend pulse
//  change_pulse out  1         1 cycle high = one COIN_A returned
//  coin_reject  out  1         1-cycle pulse: coin presented while not accepting
//  ready        out  1         high while in READY (credit >= PRICE)
//  credit       out  CREDIT_W  current credit in cents
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, credit=0, all outputs 0. Reset mid-operation loses
//    credit and aborts any partial change train.
//  - All outputs are registered. A coin or request in cycle N affects outputs at edge N+1.
//  - States: IDLE, COLLECT, READY, CHANGE.
//  - IDLE
//    - Coin: credit <= value.
//    - Next state: READY if value >= PRICE, else COLLECT.
//    - cancel and outpaper are ignored.
//  - COLLECT
//    - Coin: credit += value; go to READY when new credit >= PRICE.
//    - cancel: go to CHANGE (full refund).
//    - Coin and cancel in the same cycle: the coin is added, then all credit is refunded.
//  - READY
//    - outpaper: newspaper=1 for one cycle; credit -= PRICE.
//      Next state: IDLE if the remainder is 0, else CHANGE.
//    - cancel without outpaper: go to CHANGE with full credit.
//    - outpaper wins over a simultaneous cancel.
//    - Coin: coin_reject=1 for one cycle; credit unchanged.
//  - CHANGE
//    - Every cycle: change_pulse=1 and credit -= COIN_A.
//    - The cycle credit reaches 0: go to IDLE.
//    - Coins get coin_reject; cancel and outpaper are ignored.
//  - Arithmetic is unsigned, CREDIT_W bits. Credit can never exceed the bound above, so there
//    is no wrap. Parameter checks are enforced by an elaboration-time assertion.
//  - The 2'b00 code never changes credit. The default state branch returns to IDLE with
//    credit=0.
// STRUCTURE
//  - Shared package/include: state encodings (2-bit) and coin codes COIN_NONE/A/B/C.
//  - One sub-module: vend_coin_decode (combinational coinin -> value[CREDIT_W-1:0],
//    coin_valid).
//  - The FSM, credit register and output registers live in this module.
// TESTING  (defaults: PRICE=15, A=5, B=10, C=25)
//  1. Coins 01,01,01, then outpaper
//     -> ready rises after the 3rd coin with credit=15;
//     -> newspaper pulses once, credit=0, IDLE, no change_pulse.
//  2. Coin 11 (25), then outpaper
//     -> newspaper pulse;
//     -> exactly 2 consecutive change_pulse cycles, credit 10->5->0, then IDLE.
//  3. Coin 10, then cancel -> 2 change_pulse cycles, no newspaper, credit ends 0.
//  4. In READY with credit=20, present coin 01 -> coin_reject 1 cycle, credit stays 20.
//  5. In READY with credit=15, outpaper and cancel together -> newspaper pulse, no change.
//  6. Assert rst low mid-CHANGE (not clock-aligned) -> credit, change_pulse and ready are 0
//     immediately; first coin after release starts from credit 0.

Source files
------------

// File: rtl/vending_change_fsm_pkg.sv
// Shared types for the coin-change vending FSM: state encodings, coin codes and
// a small constant helper used by the parameter check.
package vending_change_fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_READY   = 2'b10,
    ST_CHANGE  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    COIN_NONE   = 2'b00,
    COIN_CODE_A = 2'b01,
    COIN_CODE_B = 2'b10,
    COIN_CODE_C = 2'b11
  } coin_code_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vend_coin_decode.sv
// Combinational coin decoder: maps the 2-bit acceptor code to its value in cents
// and flags whether any coin is present this cycle.
module vend_coin_decode
  import vending_change_fsm_pkg::*;
#(
  parameter int COIN_A   = 5,
  parameter int COIN_B   = 10,
  parameter int COIN_C   = 25,
  parameter int CREDIT_W = 6
) (
  input  logic [1:0]          coinin,
  output logic [CREDIT_W-1:0] value,
  output logic                coin_valid
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    value      = '0;
    coin_valid = 1'b0;
    case (coin_code_t'(coinin))
      COIN_CODE_A: begin
        value      = CREDIT_W'(COIN_A);
        coin_valid = 1'b1;
      end
      COIN_CODE_B: begin
        value      = CREDIT_W'(COIN_B);
        coin_valid = 1'b1;
      end
      COIN_CODE_C: begin
        value      = CREDIT_W'(COIN_C);
        coin_valid = 1'b1;
      end
      default: begin
        value      = '0;
        coin_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/vending_change_fsm.sv
// Multi-coin vending controller: accumulates credit toward PRICE, vends on request
// and pays change back as a train of COIN_A pulses. All outputs are registered.
module vending_change_fsm
  import vending_change_fsm_pkg::*;
#(
  parameter int PRICE    = 15,
  parameter int COIN_A   = 5,
  parameter int COIN_B   = 10,
  parameter int COIN_C   = 25,
  parameter int CREDIT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coinin,
  input  logic                outpaper,
  input  logic                cancel,
  output logic                newspaper,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                ready,
  output logic [CREDIT_W-1:0] credit
);

  localparam int MAX_CREDIT = PRICE - COIN_A + max2(COIN_B, COIN_C);
  localparam logic [CREDIT_W-1:0] PRICE_V = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] UNIT_V  = CREDIT_W'(COIN_A);

  // Credit is held in CREDIT_W bits with no saturation, so a bad parameter set
  // must be refused at elaboration rather than silently wrapping.
  generate
    if (COIN_A <= 0 || PRICE < COIN_A || (PRICE % COIN_A) != 0 ||
        (COIN_B % COIN_A) != 0 || (COIN_C % COIN_A) != 0 ||
        MAX_CREDIT >= (1 << CREDIT_W)) begin : g_param_check
      $fatal(1, "vending_change_fsm: illegal PRICE/COIN/CREDIT_W parameter set");
    end
  endgenerate

  state_t              state, state_d;
  logic [CREDIT_W-1:0] credit_d;
  logic [CREDIT_W-1:0] coin_value;
  logic                coin_valid;
  logic                newspaper_d, change_pulse_d, coin_reject_d;

  vend_coin_decode #(
    .COIN_A  (COIN_A),
    .COIN_B  (COIN_B),
    .COIN_C  (COIN_C),
    .CREDIT_W(CREDIT_W)
  ) u_coin_decode (
    .coinin    (coinin),
    .value     (coin_value),
    .coin_valid(coin_valid)
  );

  always_comb begin
    state_d        = state;
    credit_d       = credit;
    newspaper_d    = 1'b0;
    change_pulse_d = 1'b0;
    coin_reject_d  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (coin_valid) begin
          credit_d = coin_value;
          state_d  = (coin_value >= PRICE_V) ? ST_READY : ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        // A coin arriving with cancel is banked first so it is refunded too.
        credit_d = credit + coin_value;
        if (cancel)
          state_d = ST_CHANGE;
        else if (credit_d >= PRICE_V)
          state_d = ST_READY;
      end

      ST_READY: begin
        coin_reject_d = coin_valid;
        if (outpaper) begin
          newspaper_d = 1'b1;
          credit_d    = credit - PRICE_V;
          state_d     = (credit_d == '0) ? ST_IDLE : ST_CHANGE;
        end else if (cancel) begin
          state_d = ST_CHANGE;
        end
      end

      ST_CHANGE: begin
        coin_reject_d  = coin_valid;
        change_pulse_d = 1'b1;
        // Credit is always a COIN_A multiple here; the <= also catches a zero
        // balance so the train can never underflow.
        if (credit <= UNIT_V) begin
          credit_d = '0;
          state_d  = ST_IDLE;
        end else begin
          credit_d = credit - UNIT_V;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order or other processes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      credit       <= '0;
      newspaper    <= 1'b0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      ready        <= 1'b0;
    end else begin
      state        <= state_d;
      credit       <= credit_d;
      newspaper    <= newspaper_d;
      change_pulse <= change_pulse_d;
      coin_reject  <= coin_reject_d;
      ready        <= (state_d == ST_READY);
    end
  end

endmodule

// File: tb/tb_vending_change_fsm.sv
// Directed bench for vending_change_fsm with the default price and coin set.
module tb_vending_change_fsm;
  import vending_change_fsm_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coinin;
  logic       outpaper;
  logic       cancel;
  logic       newspaper;
  logic       change_pulse;
  logic       coin_reject;
  logic       ready;
  logic [5:0] credit;

  int tests_run = 0;
  int tests_failed = 0;

  vending_change_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .coinin      (coinin),
    .outpaper    (outpaper),
    .cancel      (cancel),
    .newspaper   (newspaper),
    .change_pulse(change_pulse),
    .coin_reject (coin_reject),
    .ready       (ready),
    .credit      (credit)
  );

  always #5 clk = ~clk;

  // Inputs set before a tick are sampled at the next rising edge; the outputs
  // are then read 1 ns after that edge.
  task automatic tick(input logic [1:0] c, input logic op, input logic cn);
    coinin   = c;
    outpaper = op;
    cancel   = cn;
    @(posedge clk);
    #1;
    coinin   = 2'b00;
    outpaper = 1'b0;
    cancel   = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [5:0] exp_credit,
                            input logic exp_ready, input logic exp_news,
                            input logic exp_chg, input logic exp_rej);
    tests_run++;
    if (credit !== exp_credit || ready !== exp_ready || newspaper !== exp_news ||
        change_pulse !== exp_chg || coin_reject !== exp_rej) begin
      tests_failed++;
      $display("FAIL %s: got credit=%0d ready=%b news=%b chg=%b rej=%b, expected credit=%0d ready=%b news=%b chg=%b rej=%b",
               name, credit, ready, newspaper, change_pulse, coin_reject,
               exp_credit, exp_ready, exp_news, exp_chg, exp_rej);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; coinin = 2'b01; outpaper = 1'b1; cancel = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset_held", 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    coinin = 2'b00; outpaper = 1'b0; cancel = 1'b0;
    #3 rst = 1'b1;
    tick(2'b00, 1'b1, 1'b1);
    expect_out("idle_ignores_requests", 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_exact_price();
    tick(2'b01, 1'b0, 1'b0);
    expect_out("exact_coin1", 6'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2'b01, 1'b0, 1'b0);
    expect_out("exact_coin2", 6'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2'b01, 1'b0, 1'b0);
    expect_out("exact_coin3_ready", 6'd15, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(2'b00, 1'b1, 1'b0);
    expect_out("exact_vend", 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(2'b00, 1'b0, 1'b0);
    expect_out("exact_after_vend", 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_vend_with_change();
    tick(2'b11, 1'b0, 1'b0);
    expect_out("chg_coin25", 6'd25, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(2'b00, 1'b1, 1'b0);
    expect_out("chg_vend", 6'd10, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(2'b00, 1'b0, 1'b0);
    expect_out("chg_pulse1", 6'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(2'b00, 1'b0, 1'b0);
    expect_out("chg_pulse2", 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(2'b00, 1'b0, 1'b0);
    expect_out("chg_done", 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_cancel_refund();
    tick(2'b10, 1'b0, 1'b0);
    expect_out("cancel_coin10", 6'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2'b00, 1'b0, 1'b1);
    expect_out("cancel_enter_change", 6'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2'b00, 1'b1, 1'b0);
    expect_out("cancel_pulse1_ignores_outpaper", 6'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(2'b00, 1'b0, 1'b0);
    expect_out("cancel_pulse2", 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(2'b00, 1'b0, 1'b0);
    expect_out("cancel_done", 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reject_coins();
    tick(2'b10, 1'b0, 1'b0);
    tick(2'b10, 1'b0, 1'b0);
    expect_out("rej_ready20", 6'd20, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(2'b01, 1'b0, 1'b0);
    expect_out("rej_in_ready", 6'd20, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(2'b00, 1'b0, 1'b0);
    expect_out("rej_pulse_ends", 6'd20, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(2'b00, 1'b0, 1'b1);
    expect_out("rej_cancel20", 6'd20, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2'b11, 1'b0, 1'b0);
    expect_out("rej_in_change", 6'd15, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(2'b00, 1'b0, 1'b0);
    expect_out("rej_drain10", 6'd10, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(2'b00, 1'b0, 1'b0);
    expect_out("rej_drain5", 6'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(2'b00, 1'b0, 1'b0);
    expect_out("rej_drain0", 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(2'b00, 1'b0, 1'b0);
    expect_out("rej_idle", 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_vend_beats_cancel();
    tick(2'b10, 1'b0, 1'b0);
    tick(2'b01, 1'b0, 1'b0);
    expect_out("prio_ready15", 6'd15, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(2'b00, 1'b1, 1'b1);
    expect_out("prio_vend", 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(2'b00, 1'b0, 1'b0);
    expect_out("prio_no_change", 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_coin_with_cancel();
    tick(2'b01, 1'b0, 1'b0);
    expect_out("cc_collect5", 6'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2'b10, 1'b0, 1'b1);
    expect_out("cc_banked_then_refund", 6'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2'b00, 1'b0, 1'b0);
    expect_out("cc_pulse1", 6'd10, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(2'b00, 1'b0, 1'b0);
    tick(2'b00, 1'b0, 1'b0);
    expect_out("cc_pulse3", 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(2'b00, 1'b0, 1'b0);
    expect_out("cc_idle", 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_mid_change_reset();
    tick(2'b11, 1'b0, 1'b0);
    tick(2'b00, 1'b1, 1'b0);
    tick(2'b00, 1'b0, 1'b0);
    expect_out("mr_in_change", 6'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    expect_out("mr_async_clear", 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    tick(2'b01, 1'b0, 1'b0);
    expect_out("mr_fresh_credit", 6'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2'b00, 1'b0, 1'b0);
    expect_out("mr_no_stale_train", 6'd5, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    coinin = 2'b00; outpaper = 1'b0; cancel = 1'b0;
    test_reset();
    test_exact_price();
    test_vend_with_change();
    test_cancel_refund();
    test_reject_coins();
    test_vend_beats_cancel();
    test_coin_with_cancel();
    test_mid_change_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
